// File: rtl/brc_pkg.sv
// -----------------------------------------------------------------------------
// brc_pkg
//   Shared definitions for the multi-channel buffer read controller:
//   FSM state encoding, stall-counter width and a clog2 helper used to size
//   the channel index.
// -----------------------------------------------------------------------------
package brc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } brc_state_e;

  localparam int STALL_CNT_W = 16;

  // Ceiling log2, never below 1 so a single-channel build still has a
  // 1-bit channel index.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage : brc_pkg

// File: rtl/brc_wrap_counter.sv
// -----------------------------------------------------------------------------
// brc_wrap_counter
//   Up-counter that wraps from a runtime maximum back to zero.
//   Ports:
//     clk   in   clock, rising edge
//     rst   in   asynchronous active-high reset (count -> 0)
//     clr   in   synchronous clear, has priority over en
//     en    in   advance by one
//     max   in   last value before wrapping
//     pout  out  current count (registered)
//     co    out  carry-out: en while the count sits at max
// -----------------------------------------------------------------------------
module brc_wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] pout,
  output logic             co
);

  logic [WIDTH-1:0] cnt_q;
  logic             at_max_s;

  assign at_max_s = (cnt_q == max);
  assign co       = en & at_max_s;
  assign pout     = cnt_q;

  // Count register: clear, wrap at max, or increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (at_max_s) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + WIDTH'(1);
      end
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule : brc_wrap_counter

// File: rtl/buffer_read_controller_multi.sv
// -----------------------------------------------------------------------------
// buffer_read_controller_multi
//   Loads ch_in channels of len_in words each from the filter buffer into the
//   PE scratchpads after an init pulse. Address runs 0..len-1 per channel,
//   then the channel index advances, without a bubble between channels.
//   Optional feature macro: BRC_STALL_CNT_EN adds stall_cnt, a saturating
//   count of READ cycles spent with stall asserted.
//   Ports:
//     clk, rst            clock / asynchronous active-high reset
//     init                start or restart; latches (clamped) len_in, ch_in
//     len_in, ch_in       words per channel / channels to load
//     valid, stall        buffer word available / downstream stall
//     ren_buf, wen_spad   combinational beat strobes
//     spad_waddr,spad_sel registered word address / channel index
//     busy, valid_end     in READ / in IDLE
//     done                one cycle in DONE after a completed load
//     stall_cnt           (BRC_STALL_CNT_EN only) stalled READ cycles
// -----------------------------------------------------------------------------
module buffer_read_controller_multi
  import brc_pkg::*;
#(
  parameter int SPAD_ADDR_WIDTH = 4,
  parameter int SPAD_DEPTH      = 16,
  parameter int NUM_CH          = 4,
  parameter int CH_WIDTH        = clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic [SPAD_ADDR_WIDTH:0]   len_in,
  input  logic [CH_WIDTH:0]          ch_in,
  input  logic                       valid,
  input  logic                       stall,
  output logic                       ren_buf,
  output logic                       wen_spad,
  output logic [SPAD_ADDR_WIDTH-1:0] spad_waddr,
  output logic [CH_WIDTH-1:0]        spad_sel,
  output logic                       busy,
  output logic                       valid_end,
`ifdef BRC_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0]     stall_cnt,
`endif
  output logic                       done
);

  localparam logic [SPAD_ADDR_WIDTH:0] DEPTH_C = SPAD_DEPTH[SPAD_ADDR_WIDTH:0];
  localparam logic [CH_WIDTH:0]        NCH_C   = NUM_CH[CH_WIDTH:0];

  brc_state_e                 state_q;
  // Lengths are kept as "last index" so they feed the counters' max directly;
  // a full-depth length (e.g. 16 in 4 bits) becomes all-ones.
  logic [SPAD_ADDR_WIDTH-1:0] len_m1_q;
  logic [CH_WIDTH-1:0]        chn_m1_q;
  logic [SPAD_ADDR_WIDTH:0]   len_d;
  logic [CH_WIDTH:0]          chn_d;
  logic                       zero_size_s;
  logic                       beat_s;
  logic                       addr_co_s;
  logic                       ch_co_s;

  // Clamp the requested size to what the scratchpads can hold.
  always_comb begin
    len_d = len_in;
    chn_d = ch_in;
    if (len_in > DEPTH_C) begin
      len_d = DEPTH_C;
    end else begin
      len_d = len_in;
    end
    if (ch_in > NCH_C) begin
      chn_d = NCH_C;
    end else begin
      chn_d = ch_in;
    end
  end

  assign zero_size_s = (len_d == '0) || (chn_d == '0);

  // init owns its cycle: it restarts the load, so no word moves alongside it.
  assign beat_s = (state_q == READ) & valid & ~stall & ~init;

  brc_wrap_counter #(.WIDTH(SPAD_ADDR_WIDTH)) u_addr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (init),
    .en   (beat_s),
    .max  (len_m1_q),
    .pout (spad_waddr),
    .co   (addr_co_s)
  );

  // Channel advances only on the beat that writes the last word of a channel.
  brc_wrap_counter #(.WIDTH(CH_WIDTH)) u_ch_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (init),
    .en   (addr_co_s),
    .max  (chn_m1_q),
    .pout (spad_sel),
    .co   (ch_co_s)
  );

  // Load FSM and size latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_m1_q <= '0;
      chn_m1_q <= '0;
    end else if (init) begin
      len_m1_q <= len_d[SPAD_ADDR_WIDTH-1:0] - SPAD_ADDR_WIDTH'(1);
      chn_m1_q <= chn_d[CH_WIDTH-1:0] - CH_WIDTH'(1);
      state_q  <= zero_size_s ? DONE : READ;
    end else begin
      len_m1_q <= len_m1_q;
      chn_m1_q <= chn_m1_q;
      case (state_q)
        IDLE:    state_q <= IDLE;
        READ:    state_q <= (addr_co_s & ch_co_s) ? DONE : READ;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ren_buf   = beat_s;
  assign wen_spad  = beat_s;
  assign busy      = (state_q == READ);
  assign valid_end = (state_q == IDLE);
  assign done      = (state_q == DONE);

`ifdef BRC_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating count of stalled READ cycles; restarts with each init.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (init) begin
      stall_cnt_q <= '0;
    end else if ((state_q == READ) && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : buffer_read_controller_multi

// File: tb/tb_buffer_read_controller_multi.sv
module tb_buffer_read_controller_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic [4:0] len_in;
  logic [2:0] ch_in;
  logic       valid;
  logic       stall;
  logic       ren_buf;
  logic       wen_spad;
  logic [3:0] spad_waddr;
  logic [1:0] spad_sel;
  logic       busy;
  logic       valid_end;
  logic       done;
`ifdef BRC_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  buffer_read_controller_multi dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .len_in     (len_in),
    .ch_in      (ch_in),
    .valid      (valid),
    .stall      (stall),
    .ren_buf    (ren_buf),
    .wen_spad   (wen_spad),
    .spad_waddr (spad_waddr),
    .spad_sel   (spad_sel),
    .busy       (busy),
    .valid_end  (valid_end),
`ifdef BRC_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase (0 idle, 1 loading, 2 finished), load size and
  // number of words already transferred. Address/channel follow from the
  // transfer index by division.
  int mst, mlen, mchn, midx, msc;
  int wr_cnt, done_cnt;

  typedef struct {
    bit init; int len; int ch; bit valid; bit stall;
    bit e_ren; int e_addr; int e_sel; bit e_busy; bit e_ve; bit e_done;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic model_reset();
    mst = 0; mlen = 0; mchn = 0; midx = 0; msc = 0;
  endtask

  task automatic check_model();
    int ebeat;
    ebeat = (mst == 1 && valid && !stall && !init) ? 1 : 0;
    chk("ren_buf", int'(ren_buf), ebeat);
    chk("wen_spad", int'(wen_spad), ebeat);
    chk("spad_waddr", int'(spad_waddr), (mst == 1) ? midx % mlen : 0);
    chk("spad_sel", int'(spad_sel), (mst == 1) ? midx / mlen : 0);
    chk("busy", int'(busy), (mst == 1) ? 1 : 0);
    chk("valid_end", int'(valid_end), (mst == 0) ? 1 : 0);
    chk("done", int'(done), (mst == 2) ? 1 : 0);
`ifdef BRC_STALL_CNT_EN
    chk("stall_cnt", int'(stall_cnt), msc);
`endif
    if (ren_buf) wr_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic model_edge();
    if (init) begin
      mlen = (int'(len_in) > 16) ? 16 : int'(len_in);
      mchn = (int'(ch_in) > 4) ? 4 : int'(ch_in);
      midx = 0;
      msc  = 0;
      mst  = (mlen == 0 || mchn == 0) ? 2 : 1;
    end else if (mst == 1) begin
      if (stall && msc < 65535) msc++;
      if (valid && !stall) begin
        midx++;
        if (midx == mlen * mchn) mst = 2;
      end
    end else if (mst == 2) begin
      mst = 0;
    end
  endtask

  task automatic drive(input bit i, input int l, input int c, input bit v, input bit s);
    init = i; len_in = l[4:0]; ch_in = c[2:0]; valid = v; stall = s;
  endtask

  task automatic cyc(input bit i, input int l, input int c, input bit v, input bit s);
    drive(i, l, c, v, s);
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    // len=3, chn=2, continuous valid: hand-derived expected trace.
    tbl[0] = '{1'b1, 3, 2, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 0, 1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1, 1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 2, 1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    model_reset();
    wr_cnt = 0; done_cnt = 0;
    @(negedge clk);
    check_model();
    #2 rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Test 1: table-driven.
    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].init, tbl[k].len, tbl[k].ch, tbl[k].valid, tbl[k].stall);
      @(negedge clk);
      chk("tbl_ren", int'(ren_buf), int'(tbl[k].e_ren));
      chk("tbl_addr", int'(spad_waddr), tbl[k].e_addr);
      chk("tbl_sel", int'(spad_sel), tbl[k].e_sel);
      chk("tbl_busy", int'(busy), int'(tbl[k].e_busy));
      chk("tbl_valid_end", int'(valid_end), int'(tbl[k].e_ve));
      chk("tbl_done", int'(done), int'(tbl[k].e_done));
      check_model();
      @(posedge clk);
      model_edge();
      #1;
    end

    // Test 2: stall after the 2nd write.
    wr_cnt = 0; done_cnt = 0;
    cyc(1'b1, 4, 1, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1'b1);
    chk("stall_hold_addr", int'(spad_waddr), 2);
    cyc(1'b0, 0, 0, 1'b1, 1'b1);
    chk("stall_hold_addr2", int'(spad_waddr), 2);
`ifdef BRC_STALL_CNT_EN
    chk("stall_cnt_two", int'(stall_cnt), 2);
`endif
    for (int k = 0; k < 4; k++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t2_writes", wr_cnt, 4);
    chk("t2_dones", done_cnt, 1);

    // Test 3: valid toggling.
    wr_cnt = 0; done_cnt = 0;
    cyc(1'b1, 2, 2, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) cyc(1'b0, 0, 0, (k % 2) == 0, 1'b0);
    chk("t3_writes", wr_cnt, 4);
    chk("t3_dones", done_cnt, 1);

    // Test 4: restart during READ at ch1/a1.
    cyc(1'b1, 2, 2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t4_at_sel", int'(spad_sel), 1);
    chk("t4_at_addr", int'(spad_waddr), 1);
    wr_cnt = 0; done_cnt = 0;
    cyc(1'b1, 1, 3, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t4_writes", wr_cnt, 3);
    chk("t4_dones", done_cnt, 1);

    // Test 5: zero-size loads and clamping.
    wr_cnt = 0; done_cnt = 0;
    cyc(1'b1, 0, 2, 1'b1, 1'b0);
    chk("t5_len0_done", int'(done), 1);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    cyc(1'b1, 3, 0, 1'b1, 1'b0);
    chk("t5_ch0_done", int'(done), 1);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t5_zero_writes", wr_cnt, 0);
    chk("t5_zero_dones", done_cnt, 2);
    wr_cnt = 0; done_cnt = 0;
    cyc(1'b1, 20, 1, 1'b1, 1'b0);
    for (int k = 0; k < 18; k++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t5_len_clamp_writes", wr_cnt, 16);
    wr_cnt = 0;
    cyc(1'b1, 1, 7, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t5_ch_clamp_writes", wr_cnt, 4);

    // Test 6: asynchronous reset mid-READ.
    cyc(1'b1, 3, 2, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_ren", int'(ren_buf), 0);
    chk("arst_valid_end", int'(valid_end), 1);
    chk("arst_busy", int'(busy), 0);
    chk("arst_addr", int'(spad_waddr), 0);
    chk("arst_sel", int'(spad_sel), 0);
    chk("arst_done", int'(done), 0);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    wr_cnt = 0;
    for (int k = 0; k < 4; k++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
    chk("arst_no_writes", wr_cnt, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 20), $urandom_range(0, 6),
          $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_buffer_read_controller_multi
